// File: rtl/storage_arbiter.sv
// storage_arbiter: round-robin arbiter that shares one registered-read storage
// unit among NREQ requesters. A requester can hold the port for a bounded run of
// back-to-back grants by asserting its lock bit.
module storage_arbiter #(
  parameter int NREQ     = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int MAX_LOCK = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ-1:0]       re,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_data_in,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [WIDTH-1:0]      mem_data_out
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [PW-1:0] LAST     = PW'(NREQ - 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            ownerValid_q, ownerValid_d;
  logic [CW-1:0]   lockCnt_q, lockCnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic            winValid;
  logic [PW-1:0]   winIdx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] gntOneHot;
  logic [CW-1:0]   grantNum;
  logic [PW-1:0]   nextIdx;
  logic [PW-1:0]   ownerNext;
  int              idx;

  // Pick the winner: a live locked owner keeps the port, otherwise search from ptr.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    idx      = 0;
    cand     = '0;
    if (ownerValid_q && req[owner_q] && (lockCnt_q < LOCK_MAX)) begin
      winValid = 1'b1;
      winIdx   = owner_q;
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= NREQ) idx = idx - NREQ;
        cand = PW'(idx);
        if (!winValid && req[cand]) begin
          winValid = 1'b1;
          winIdx   = cand;
        end
      end
    end
    if (!rst_n) winValid = 1'b0;
    gntOneHot = '0;
    if (winValid) gntOneHot[winIdx] = 1'b1;
  end

  // Route the winner's access onto the storage port; everything idles without a grant.
  always_comb begin
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winValid && (winIdx == PW'(i))) begin
        mem_addr     = addr[i*AW +: AW];
        mem_data_in  = wdata[i*WIDTH +: WIDTH];
        mem_write_en = we[i];
        mem_read_en  = re[i];
      end
    end
  end

  // Work out lock-run bookkeeping, pointer advance and the read strobe for next cycle.
  always_comb begin
    grantNum     = (ownerValid_q && (owner_q == winIdx)) ? lockCnt_q + CW'(1) : CW'(1);
    nextIdx      = (winIdx == LAST) ? '0 : winIdx + PW'(1);
    ownerNext    = (owner_q == LAST) ? '0 : owner_q + PW'(1);
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    ownerValid_d = ownerValid_q;
    lockCnt_d    = lockCnt_q;
    if (winValid) begin
      if (lock[winIdx] && (grantNum < LOCK_MAX)) begin
        owner_d      = winIdx;
        ownerValid_d = 1'b1;
        lockCnt_d    = grantNum;
      end else begin
        ownerValid_d = 1'b0;
        lockCnt_d    = '0;
        ptr_d        = nextIdx;
      end
    end else if (ownerValid_q && !req[owner_q]) begin
      ownerValid_d = 1'b0;
      lockCnt_d    = '0;
      ptr_d        = ownerNext;
    end
    rvalid_d = (winValid && mem_read_en) ? gntOneHot : '0;
  end

  // Arbitration state and read strobe registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      ownerValid_q <= 1'b0;
      lockCnt_q    <= '0;
      rvalid_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      ownerValid_q <= ownerValid_d;
      lockCnt_q    <= lockCnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign gnt    = gntOneHot;
  assign rvalid = rvalid_q;
  assign rdata  = mem_data_out;

endmodule

// File: tb/tb_storage_arbiter.sv
// tb_storage_arbiter: table-driven bench with a read-return scoreboard and a
// behavioural model of the storage unit attached to the memory port.
module tb_storage_arbiter;

  localparam int NREQ     = 2;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int MAX_LOCK = 4;
  localparam int AW       = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req, lock, we, re;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt, rvalid;
  logic [WIDTH-1:0]      rdata;
  logic [AW-1:0]         memAddr;
  logic [WIDTH-1:0]      memDataIn, memDataOut;
  logic                  memWriteEn, memReadEn;

  typedef struct {
    logic [1:0] req, lock, we, re;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] expGnt;
    string      name;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } rd_t;

  vec_t       vecs[$];
  rd_t        scoreboard[$];
  logic [7:0] refMem[DEPTH];
  logic [7:0] store[DEPTH];
  int         checks = 0;
  int         failures = 0;

  storage_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(memAddr), .mem_data_in(memDataIn), .mem_write_en(memWriteEn),
    .mem_read_en(memReadEn), .mem_data_out(memDataOut)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Storage unit model: registered read returns the value from before a same-cycle write
  always @(posedge clk) begin
    if (memWriteEn) store[memAddr] <= memDataIn;
    if (memReadEn) memDataOut <= store[memAddr];
  end

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] rq, input logic [1:0] lk,
                              input logic [1:0] w, input logic [1:0] r,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eg);
    vec_t v;
    v.name = name; v.req = rq; v.lock = lk; v.we = w; v.re = r;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.expGnt = eg;
    return v;
  endfunction

  // Read return expected this cycle (if any) from the previous cycle's accepted read
  task automatic checkReturn(input string tag);
    rd_t r;
    logic [1:0] oneHot;
    if (scoreboard.size() > 0) begin
      r = scoreboard.pop_front();
      oneHot = 2'b00;
      oneHot[r.idx] = 1'b1;
      compare({tag, ".rvalid"}, rvalid, oneHot);
      compare({tag, ".rdata"}, rdata, r.data);
    end else begin
      compare({tag, ".rvalid_idle"}, rvalid, 2'b00);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    int w;
    logic granted;
    w = v.expGnt[1] ? 1 : 0;
    granted = (v.expGnt != 2'b00);
    compare({v.name, ".gnt"}, gnt, v.expGnt);
    compare({v.name, ".mem_write_en"}, memWriteEn, granted & v.we[w]);
    compare({v.name, ".mem_read_en"}, memReadEn, granted & v.re[w]);
    if (granted) begin
      compare({v.name, ".mem_addr"}, memAddr, (w == 1) ? v.a1 : v.a0);
      if (v.we[w]) compare({v.name, ".mem_data_in"}, memDataIn, (w == 1) ? v.d1 : v.d0);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int w;
    logic [3:0] a;
    @(negedge clk);
    checkReturn(v.name);
    req = v.req; lock = v.lock; we = v.we; re = v.re;
    addr = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
    #1;
    checkOutput(v);
    if (v.expGnt != 2'b00) begin
      w = v.expGnt[1] ? 1 : 0;
      a = (w == 1) ? v.a1 : v.a0;
      if (v.re[w]) scoreboard.push_back('{w, refMem[a]});
      if (v.we[w]) refMem[a] = (w == 1) ? v.d1 : v.d0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = 8'h00;
      store[i]  = 8'h00;
    end
    memDataOut = 8'h00;

    // Reset held with everyone requesting
    req = 2'b11; lock = 2'b00; we = 2'b11; re = 2'b11; addr = '0; wdata = '0;
    #12;
    compare("reset.gnt", gnt, 2'b00);
    compare("reset.rvalid", rvalid, 2'b00);
    compare("reset.mem_write_en", memWriteEn, 1'b0);
    compare("reset.mem_read_en", memReadEn, 1'b0);
    @(negedge clk);
    req = 2'b00; we = 2'b00; re = 2'b00;
    rst_n = 1'b1;

    // Round-robin writes, write/read, pipelined reads, read+write, no-access slot
    vecs.push_back(mk("rr0", 2'b11, 2'b00, 2'b11, 2'b00, 4'd1, 4'd2, 8'h11, 8'h22, 2'b01));
    vecs.push_back(mk("rr1", 2'b11, 2'b00, 2'b11, 2'b00, 4'd1, 4'd2, 8'h11, 8'h22, 2'b10));
    vecs.push_back(mk("rr2", 2'b11, 2'b00, 2'b11, 2'b00, 4'd4, 4'd5, 8'h33, 8'h44, 2'b01));
    vecs.push_back(mk("rr3", 2'b11, 2'b00, 2'b11, 2'b00, 4'd4, 4'd5, 8'h33, 8'h44, 2'b10));
    vecs.push_back(mk("wr0", 2'b01, 2'b00, 2'b01, 2'b00, 4'd3, 4'd0, 8'hA5, 8'h00, 2'b01));
    vecs.push_back(mk("rd1", 2'b10, 2'b00, 2'b00, 2'b10, 4'd0, 4'd3, 8'h00, 8'h00, 2'b10));
    vecs.push_back(mk("idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00));
    vecs.push_back(mk("bb0", 2'b11, 2'b00, 2'b00, 2'b11, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("bb1", 2'b11, 2'b00, 2'b00, 2'b11, 4'd1, 4'd5, 8'h00, 8'h00, 2'b10));
    vecs.push_back(mk("rw0", 2'b01, 2'b00, 2'b01, 2'b01, 4'd3, 4'd0, 8'h5A, 8'h00, 2'b01));
    vecs.push_back(mk("rd0", 2'b01, 2'b00, 2'b00, 2'b01, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("noacc", 2'b10, 2'b00, 2'b00, 2'b00, 4'd7, 4'd9, 8'h00, 8'h00, 2'b10));
    vecs.push_back(mk("idle2", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00));
    // Lock limit run, then lock release when the owner drops its request
    vecs.push_back(mk("lk1", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("lk2", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("lk3", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("lk4", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("lk5", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b10));
    vecs.push_back(mk("lk6", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("rel1", 2'b11, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("rel2", 2'b10, 2'b01, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b10));
    vecs.push_back(mk("rel3", 2'b11, 2'b00, 2'b00, 2'b00, 4'd6, 4'd8, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("idle3", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset asserted while a read is in flight: no strobe may appear afterwards
    @(negedge clk);
    checkReturn("pre_rst");
    req = 2'b01; lock = 2'b00; we = 2'b00; re = 2'b01; addr = {4'd0, 4'd3};
    #1;
    compare("midrst.gnt_before", gnt, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    compare("midrst.gnt_in_reset", gnt, 2'b00);
    compare("midrst.read_en_in_reset", memReadEn, 1'b0);
    @(posedge clk);
    #1;
    compare("midrst.rvalid_edge", rvalid, 2'b00);
    @(negedge clk);
    req = 2'b00; re = 2'b00;
    rst_n = 1'b1;
    scoreboard.delete();
    @(negedge clk);
    compare("midrst.rvalid_after1", rvalid, 2'b00);

    // Pointer back at 0 after reset
    vecs.delete();
    vecs.push_back(mk("post_rst", 2'b11, 2'b00, 2'b00, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00, 2'b01));
    vecs.push_back(mk("post_idle", 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00));
    foreach (vecs[i]) applyStimulus(vecs[i]);
    @(negedge clk);
    checkReturn("final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
